// File: rtl/guess_validator.sv
// guess_validator
//   Dictionary checker placed between letter selection and the game FSM.
//   A start pulse captures a 5-letter guess. The guess is rejected if any
//   letter is blank or illegal. Otherwise the combinational word ROM is
//   scanned one entry per cycle for an exact match. The result is reported
//   with a one-cycle done pulse.
//
// Ports
//   logicclk    in   clock, rising edge
//   clr         in   asynchronous reset, active-high
//   start       in   request pulse, sampled only in IDLE
//   guess       in   25b, letter i at guess[5*i +: 5] (0 blank, 1..26 A..Z)
//   dict_index  out  IDX_W, registered ROM address
//   dict_word   in   25b, ROM data for dict_index (same cycle)
//   busy        out  high in CHECK, SCAN and REPORT
//   done        out  one-cycle pulse in REPORT
//   accepted    out  result of the last check
//   bad_letter  out  last reject was caused by a blank/illegal letter
//
// Build option
//   GUESS_VALIDATOR_BYPASS_EN : drop the dictionary scan; every guess with
//   legal letters is accepted straight from CHECK.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | letter legality test on the captured guess
// SCAN   | compare one ROM entry per cycle
// REPORT | done pulse, results valid

module guess_validator #(
  parameter int DICT_SIZE = 100,
  parameter int IDX_W     = 7
) (
  input  logic             logicclk,
  input  logic             clr,
  input  logic             start,
  input  logic [24:0]      guess,
  output logic [IDX_W-1:0] dict_index,
  input  logic [24:0]      dict_word,
  output logic             busy,
  output logic             done,
  output logic             accepted,
  output logic             bad_letter
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_SCAN   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DICT_SIZE - 1);

  state_t           r_state;
  logic [24:0]      r_guess_q;
  logic [IDX_W-1:0] r_dict_index;
  logic             r_busy;
  logic             r_done;
  logic             r_accepted;
  logic             r_bad_letter;

  logic w_bad;
  logic w_match;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (r_guess_q[5*i +: 5] == 5'd0 || r_guess_q[5*i +: 5] > 5'd26)
        w_bad = 1'b1;
    end
  end

`ifdef GUESS_VALIDATOR_BYPASS_EN
  // ROM data is not consulted in this build.
  logic w_unused_word;
  assign w_unused_word = ^dict_word;
  assign w_match       = 1'b0;
`else
  assign w_match = (dict_word == r_guess_q);
`endif

  always_ff @(posedge logicclk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_guess_q    <= '0;
      r_dict_index <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_accepted   <= 1'b0;
      r_bad_letter <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_guess_q    <= guess;
            r_accepted   <= 1'b0;
            r_bad_letter <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_bad_letter <= 1'b1;
            r_accepted   <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_REPORT;
          end else begin
`ifdef GUESS_VALIDATOR_BYPASS_EN
            r_accepted   <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= S_REPORT;
`else
            r_dict_index <= '0;
            r_state      <= S_SCAN;
`endif
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_accepted <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_REPORT;
          end else if (r_dict_index == LAST_IDX) begin
            // last entry checked; index stays put so it never passes DICT_SIZE-1
            r_accepted <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_REPORT;
          end else begin
            r_dict_index <= r_dict_index + 1'b1;
          end
        end
        S_REPORT: begin
          r_busy       <= 1'b0;
          r_dict_index <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dict_index = r_dict_index;
  assign busy       = r_busy;
  assign done       = r_done;
  assign accepted   = r_accepted;
  assign bad_letter = r_bad_letter;

endmodule

// File: tb/tb_guess_validator.sv
// tb_guess_validator
//   Directed bench for guess_validator. The bench provides the word ROM:
//   entry k has letters {k%26+1, k/26+1, 5, (7k)%26+1, 1}, all distinct
//   across k = 0..99. Latency is counted with the start-sampling edge as 1.

module tb_guess_validator;

  logic        logicclk;
  logic        clr;
  logic        start;
  logic [24:0] guess;
  logic [6:0]  dict_index;
  logic [24:0] dict_word;
  logic        busy;
  logic        done;
  logic        accepted;
  logic        bad_letter;

  int checks = 0;
  int errors = 0;

`ifdef GUESS_VALIDATOR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  guess_validator #(.DICT_SIZE(100), .IDX_W(7)) dut (
    .logicclk   (logicclk),
    .clr        (clr),
    .start      (start),
    .guess      (guess),
    .dict_index (dict_index),
    .dict_word  (dict_word),
    .busy       (busy),
    .done       (done),
    .accepted   (accepted),
    .bad_letter (bad_letter)
  );

  initial logicclk = 1'b0;
  always #5 logicclk = ~logicclk;

  function automatic logic [24:0] mk(input int l0, input int l1, input int l2,
                                     input int l3, input int l4);
    logic [24:0] w;
    w = {5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    return w;
  endfunction

  function automatic logic [24:0] rom_word(input int k);
    return mk(k % 26 + 1, k / 26 + 1, 5, (k * 7) % 26 + 1, 1);
  endfunction

  assign dict_word = rom_word(int'(dict_index));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it to completion; sampling #1 after each edge.
  task automatic run_guess(input string tag, input logic [24:0] g,
                           output int lat, output int peak, output int ndone);
    @(negedge logicclk);
    guess = g;
    start = 1'b1;
    @(posedge logicclk);
    #1;
    start = 1'b0;
    guess = ~g;
    lat   = 0;
    peak  = 0;
    ndone = 0;
    chk({tag, "_busy_at_start"}, int'(busy), 1);
    chk({tag, "_acc_cleared"}, int'(accepted), 0);
    for (int j = 0; j < 300; j++) begin
      if (int'(dict_index) > peak) peak = int'(dict_index);
      if (done) begin
        ndone++;
        if (lat == 0) lat = j + 1;
      end
      if (lat != 0 && !done) break;
      @(posedge logicclk);
      #1;
    end
  endtask

  int lat, peak, nd;

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    guess = '0;
    repeat (3) @(posedge logicclk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_acc", int'(accepted), 0);
    chk("rst_bad", int'(bad_letter), 0);
    chk("rst_idx", int'(dict_index), 0);
    clr = 1'b0;

    // entry 0
    run_guess("e0", rom_word(0), lat, peak, nd);
    chk("e0_lat", lat, BYP ? 2 : 3);
    chk("e0_acc", int'(accepted), 1);
    chk("e0_bad", int'(bad_letter), 0);
    chk("e0_busy_after", int'(busy), 0);

    // last entry
    run_guess("e99", rom_word(99), lat, peak, nd);
    chk("e99_lat", lat, BYP ? 2 : 102);
    chk("e99_acc", int'(accepted), 1);
    chk("e99_peak", peak, BYP ? 0 : 99);
    chk("e99_idx_after", int'(dict_index), 0);

    // absent word (letter 1 = 26 never occurs in the ROM)
    run_guess("miss", mk(1, 26, 5, 1, 1), lat, peak, nd);
    chk("miss_lat", lat, BYP ? 2 : 102);
    chk("miss_acc", int'(accepted), BYP ? 1 : 0);
    chk("miss_bad", int'(bad_letter), 0);
    chk("miss_peak", peak, BYP ? 0 : 99);

    // blank letter 2
    run_guess("blank", mk(1, 2, 0, 4, 5), lat, peak, nd);
    chk("blank_lat", lat, 2);
    chk("blank_bad", int'(bad_letter), 1);
    chk("blank_acc", int'(accepted), 0);
    chk("blank_peak", peak, 0);

    // illegal letter 4
    run_guess("ill", mk(1, 2, 3, 4, 27), lat, peak, nd);
    chk("ill_lat", lat, 2);
    chk("ill_bad", int'(bad_letter), 1);
    chk("ill_acc", int'(accepted), 0);

    // a fresh capture clears bad_letter
    run_guess("e20", rom_word(20), lat, peak, nd);
    chk("e20_lat", lat, BYP ? 2 : 23);
    chk("e20_acc", int'(accepted), 1);
    chk("e20_bad", int'(bad_letter), 0);

`ifndef GUESS_VALIDATOR_BYPASS_EN
    // start during SCAN and in the done cycle must be ignored
    begin
      int dones;
      int first;
      int seen_done;
      dones = 0;
      first = 0;
      seen_done = 0;
      @(negedge logicclk);
      guess = rom_word(10);
      start = 1'b1;
      @(posedge logicclk);
      #1;
      start = 1'b0;
      for (int j = 0; j < 60; j++) begin
        if (j == 4) begin
          start = 1'b1;
          guess = mk(1, 26, 5, 1, 1);
        end
        if (j == 5) start = 1'b0;
        if (done) begin
          dones++;
          if (first == 0) first = j + 1;
          start = 1'b1;
          seen_done = 1;
        end else if (seen_done == 1) begin
          start = 1'b0;
          seen_done = 2;
        end
        @(posedge logicclk);
        #1;
      end
      start = 1'b0;
      chk("ign_lat", first, 13);
      chk("ign_dones", dones, 1);
      chk("ign_acc", int'(accepted), 1);
      chk("ign_busy", int'(busy), 0);
    end

    // reset while scanning at index 5
    begin
      int hit;
      hit = 0;
      @(negedge logicclk);
      guess = rom_word(99);
      start = 1'b1;
      @(posedge logicclk);
      #1;
      start = 1'b0;
      for (int j = 0; j < 50; j++) begin
        if (dict_index == 7'd5) begin
          hit = 1;
          break;
        end
        @(posedge logicclk);
        #1;
      end
      chk("rs_reached_idx5", hit, 1);
      #2;
      clr = 1'b1;
      #1;
      chk("rs_idx", int'(dict_index), 0);
      chk("rs_busy", int'(busy), 0);
      chk("rs_done", int'(done), 0);
      chk("rs_acc", int'(accepted), 0);
      chk("rs_bad", int'(bad_letter), 0);
      clr = 1'b0;
      // no done may surface for the aborted check
      nd = 0;
      for (int j = 0; j < 5; j++) begin
        @(posedge logicclk);
        #1;
        if (done) nd++;
      end
      chk("rs_no_done", nd, 0);
    end

    run_guess("post_rst", rom_word(0), lat, peak, nd);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_acc", int'(accepted), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_validator.md
# guess_validator

Sequential dictionary checker between the letter-selection stage and the main game FSM. On a `start` pulse it captures a 5-letter guess, rejects guesses with blank or out-of-range letters, then scans a combinational word ROM one entry per cycle for an exact match. It reports accept or reject with a one-cycle `done` pulse. The game FSM advances the row only on an accept.

## Interface
- `DICT_SIZE`, 100, number of dictionary entries scanned (index 0..DICT_SIZE-1); must be ≥1 and ≤ 2^IDX_W
- `IDX_W`, 7, width of the dictionary index
- `logicclk`  in  1  logic clock; all state changes on its rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `start`  in  1  request pulse; sampled only in IDLE
- `guess`  in  25  letter i at `guess[5*i +: 5]`, i=0..4; code 0 = blank, 1..26 = A..Z, 27..31 illegal
- `dict_index`  out  IDX_W  ROM address; registered
- `dict_word`  in  25  ROM data for `dict_index`, same packing as `guess`, valid combinationally in the same cycle
- `busy`  out  1  high in CHECK, SCAN and REPORT
- `done`  out  1  one-cycle pulse in REPORT
- `accepted`  out  1  result of the last check; held until the next accepted `start`
- `bad_letter`  out  1  last reject was caused by a blank or illegal letter; held like `accepted`

## Operation
- States:
  - IDLE: `start`=1 latches `guess` into `guess_q`, clears `accepted`/`bad_letter`, and goes to CHECK.
  - CHECK: if any letter of `guess_q` is 0 or >26, set `bad_letter`=1, `accepted`=0, and go to REPORT. Otherwise set `dict_index`=0 and go to SCAN.
  - SCAN: compare `dict_word` with `guess_q` (all 25 bits).
    - Match: `accepted`=1, go to REPORT.
    - No match and `dict_index`==DICT_SIZE-1: `accepted`=0, go to REPORT.
    - Otherwise `dict_index`+1 and stay in SCAN.
  - REPORT: `done`=1 for this cycle only. Return to IDLE and reset `dict_index` to 0.
- `dict_index` never exceeds DICT_SIZE-1. No wrap-around is permitted.
- `start` in CHECK, SCAN or REPORT is ignored; no queuing.
- Changes to `guess` after capture have no effect.
- Only the outputs of the last completed check are valid. `accepted` and `bad_letter` are cleared on capture, so they read 0 while `busy`=1.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `accepted` 0, `bad_letter` 0, `dict_index` 0, `guess_q` 0.
- Asynchronous `clr` during any state returns to IDLE at once. No `done` is emitted for the aborted check.
- `start` is sampled at edge 0, which enters CHECK. `busy` is high from edge 0 until the edge leaving REPORT.
- Illegal-letter reject: `done` is high in the cycle after edge 1 (latency 2).
- Match at dictionary index k: SCAN is entered at edge 1. `done` is high after edge 2+k (latency 3+k).
- No match: `done` is high after edge 1+DICT_SIZE (latency DICT_SIZE+2).
- `start` asserted in the same cycle as `done` (REPORT) is ignored. The next capture is possible at the first IDLE cycle.

## Configuration
- `GUESS_VALIDATOR_BYPASS_EN`:
  - Defined: the SCAN state is removed. CHECK goes straight to REPORT with `accepted`=1 for any guess with all letters legal. `dict_index` stays 0. Legal-guess latency is 2.
  - Undefined: full dictionary scan as described above.

## Test plan
- Reset mid-SCAN: assert `clr` while `dict_index`=5 → all outputs 0 immediately. A new `start` behaves normally.
- Guess equal to ROM entry 0 → `done` at latency 3, `accepted`=1, `bad_letter`=0.
- Guess equal to entry DICT_SIZE-1 (99) → `done` at latency 102, `accepted`=1, `dict_index` peaks at 99.
- Guess absent from the ROM → `done` at latency 102, `accepted`=0, `bad_letter`=0, `dict_index` never reaches 100.
- Guess with letter 2 = 0, then another with letter 4 = 27 → each gives `done` at latency 2, `bad_letter`=1, `accepted`=0, no SCAN cycles.
- `start` pulsed during SCAN and in the `done` cycle → ignored: one `done` per accepted request, result unchanged.
- Bypass build: any legal guess → `done` at latency 2, `accepted`=1.
